rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
Arbitrates one single-ported, synchronous-read memory between the CPU instruction-fetch port (I) and the load/store port (D), so the core can run from a unified memory. Sits between rv32i_cpu and the memory. Data accesses have priority, and a starvation counter guarantees fetch progress. The arbiter accepts one access per cycle, and every accepted access gets exactly one response one cycle later, routed back to the port that issued it.

Parameters:
ADDR_W, 32, address width of both ports and the memory.
STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins the next arbitration; range 1..15.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_valid  in  1  fetch request (read only)
i_addr  in  ADDR_W  fetch address
i_ready  out  1  fetch request accepted this cycle
i_rsp_valid  out  1  fetch data valid
i_rsp_rdata  out  32  fetch data
d_valid  in  1  data request
d_addr  in  ADDR_W  data address
d_we  in  1  1 = store, 0 = load
d_wstrb  in  4  byte strobes for stores
d_wdata  in  32  store data
d_ready  out  1  data request accepted this cycle
d_rsp_valid  out  1  load data valid, or store acknowledge
d_rsp_rdata  out  32  load data; 0 for a store acknowledge
mem_en  out  1  memory access this cycle
mem_wstrb  out  4  byte write strobes; 0 = read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  read data, valid the cycle after mem_en

Behaviour:
- Arbitration is combinational within a cycle:
  - grant_d = d_valid & ~(force_i & i_valid)
  - grant_i = i_valid & ~grant_d
  - d_ready = grant_d; i_ready = grant_i; mem_en = grant_d | grant_i.
- Memory outputs when grant_d: mem_addr = d_addr, mem_wdata = d_wdata, mem_wstrb = d_we ? d_wstrb : 4'b0.
- Memory outputs when grant_i: mem_addr = i_addr, mem_wstrb = 0, mem_wdata = 0.
- Memory outputs with no grant: mem_addr, mem_wdata and mem_wstrb are 0.
- A store with d_wstrb = 0 is still granted and acknowledged; the memory performs no write.
- Addresses pass through unchanged; alignment is not checked.
- Starvation counter starve_cnt, 4 bits:
  - clears on any fetch grant, or when i_valid = 0;
  - increments when i_valid & ~grant_i, saturating at STARVE_LIMIT.
  - force_i = (starve_cnt == STARVE_LIMIT).
- Response pipeline registers, updated every cycle:
  - pend_i <= grant_i;
  - pend_d <= grant_d;
  - pend_st <= grant_d & d_we.
- Responses, exactly one cycle after acceptance:
  - i_rsp_valid = pend_i; i_rsp_rdata = pend_i ? mem_rdata : 0.
  - d_rsp_valid = pend_d; d_rsp_rdata = (pend_d & ~pend_st) ? mem_rdata : 0.
  - At most one of i_rsp_valid and d_rsp_valid is high in any cycle.
- Throughput: back-to-back accepts are allowed every cycle. A requester may issue a new request in the same cycle it receives a response.
- Simultaneous requests: D wins, unless force_i is set. When force_i is set, I wins and starve_cnt clears.
- Requesters must hold their valid and payload stable until ready. The arbiter has no queue; a request that is not granted is simply re-arbitrated next cycle.
- Reset, asynchronous, clears starve_cnt, pend_i, pend_d and pend_st.
  - While reset is high, mem_en, i_ready and d_ready are forced to 0.
  - All rsp_valid outputs and rdata outputs are 0 during reset.
  - An access accepted in the cycle reset asserts produces no response.
- Outputs after reset release: all outputs are 0 until a request arrives.

Test Plan:
- Fetch only: i_valid=1, i_addr=0x10, mem returns 0x00500093 -> i_ready=1 same cycle, mem_wstrb=0; next cycle i_rsp_valid=1, rdata=0x00500093; d_rsp_valid=0.
- Store then load: d store to 0x8, data 0xDEADBEEF, wstrb=0xF; then d load from 0x8 -> mem_wstrb=0xF for the store; store ack d_rsp_valid=1 with rdata=0; load response rdata=0xDEADBEEF two cycles after the store.
- Contention, STARVE_LIMIT=4: i_valid and d_valid held high for 10 cycles -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt reaches 4 exactly before each I grant; responses are routed to the matching port.
- Pipelined fetch: i_valid high for 5 cycles with addresses 0,4,8,C,10 and no D traffic -> five consecutive i_rsp_valid pulses carrying the data in address order, each lagging its accept by 1 cycle.
- Reset mid-access: assert reset asynchronously, between clock edges, in a cycle where d_valid=1 and d_ready=1 -> d_ready falls with reset; no d_rsp_valid on the following edge; starve_cnt=0; mem_en=0 while reset is high.
- Zero-strobe store and idle: d_we=1, d_wstrb=0 -> granted with mem_wstrb=0 and acknowledged next cycle; with both valids low -> mem_en=0 and no responses for 5 cycles.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// Shares one synchronous-read memory between instruction fetch (I) and load/store (D).
// D has priority; a saturating starvation counter hands I the next arbitration once it has been denied too long.
module rv32i_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rsp_valid,
    output logic [31:0]       i_rsp_rdata,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       pend_i_q, pend_i_d;
    logic       pend_d_q, pend_d_d;
    logic       pend_st_q, pend_st_d;
    logic       force_i;
    logic       grant_d;
    logic       grant_i;

    assign force_i = (starve_cnt_q == LIMIT);

    // Grants are held off during reset so nothing reaches memory or gets a response.
    always_comb begin
        grant_d   = ~reset & d_valid & ~(force_i & i_valid);
        grant_i   = ~reset & i_valid & ~grant_d;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (grant_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_we ? d_wstrb : 4'b0000;
        end else if (grant_i) begin
            mem_addr = i_addr;
        end
    end

    assign d_ready = grant_d;
    assign i_ready = grant_i;
    assign mem_en  = grant_d | grant_i;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_i || !i_valid) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        pend_i_d  = grant_i;
        pend_d_d  = grant_d;
        pend_st_d = grant_d & d_we;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            pend_i_q     <= 1'b0;
            pend_d_q     <= 1'b0;
            pend_st_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pend_i_q     <= pend_i_d;
            pend_d_q     <= pend_d_d;
            pend_st_q    <= pend_st_d;
        end
    end

    // Store acknowledges carry zero data, not whatever the memory read back.
    assign i_rsp_valid = pend_i_q;
    assign i_rsp_rdata = pend_i_q ? mem_rdata : 32'h0;
    assign d_rsp_valid = pend_d_q;
    assign d_rsp_rdata = (pend_d_q & ~pend_st_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a small word-addressed memory model.
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_ready, i_rsp_valid;
    logic [31:0] i_addr, i_rsp_rdata;
    logic        d_valid, d_we, d_ready, d_rsp_valid;
    logic [31:0] d_addr, d_wdata, d_rsp_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_en;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:63];

    rv32i_mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_we(d_we), .d_wstrb(d_wstrb),
        .d_wdata(d_wdata), .d_ready(d_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .mem_en(mem_en), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        return (k == 4) ? 32'h00500093 : {16'hA5A5, 16'(k)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        i_valid = 0; i_addr = 0;
        d_valid = 0; d_we = 0; d_addr = 0; d_wstrb = 0; d_wdata = 0;
    endtask

    initial begin
        logic prev_i;
        logic [31:0] exp_word;
        int exp_cnt [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

        reset = 1'b1;
        idle();
        i_valid = 1; d_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_i_rsp", i_rsp_valid, 0);
        chk("rst_d_rsp", d_rsp_valid, 0);

        @(negedge clk); idle(); reset = 1'b0;
        #1;
        chk("post_rst_mem_en", mem_en, 0);
        chk("post_rst_mem_addr", mem_addr, 0);
        chk("post_rst_i_rsp_rdata", i_rsp_rdata, 0);
        chk("post_rst_d_rsp_rdata", d_rsp_rdata, 0);

        // fetch only
        @(negedge clk); i_valid = 1; i_addr = 32'h10;
        #1;
        chk("fetch_i_ready", i_ready, 1);
        chk("fetch_mem_addr", mem_addr, 32'h10);
        chk("fetch_mem_wstrb", mem_wstrb, 0);
        @(negedge clk); idle();
        #1;
        chk("fetch_rsp_valid", i_rsp_valid, 1);
        chk("fetch_rsp_rdata", i_rsp_rdata, 32'h00500093);
        chk("fetch_d_rsp", d_rsp_valid, 0);

        // pipelined fetch 0,4,8,C,10
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_valid = (c < 5); i_addr = (c < 5) ? 32'(c * 4) : 32'h0;
            #1;
            exp_word = (c > 0) ? init_word(c - 1) : 32'h0;
            chk($sformatf("pipe_i_ready_%0d", c), i_ready, 32'(c < 5));
            chk($sformatf("pipe_rsp_valid_%0d", c), i_rsp_valid, 32'(c > 0));
            chk($sformatf("pipe_rsp_rdata_%0d", c), i_rsp_rdata, exp_word);
        end
        idle();

        // store then load
        @(negedge clk);
        d_valid = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        #1;
        chk("st_d_ready", d_ready, 1);
        chk("st_mem_wstrb", mem_wstrb, 4'hF);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_mem_addr", mem_addr, 32'h8);
        @(negedge clk);
        d_we = 0; d_wstrb = 0; d_wdata = 0;
        #1;
        chk("ld_mem_wstrb", mem_wstrb, 0);
        chk("ld_mem_wdata", mem_wdata, 0);
        chk("st_ack_valid", d_rsp_valid, 1);
        chk("st_ack_rdata", d_rsp_rdata, 0);
        @(negedge clk); idle();
        #1;
        chk("ld_rsp_valid", d_rsp_valid, 1);
        chk("ld_rsp_rdata", d_rsp_rdata, 32'hDEADBEEF);
        chk("ld_i_rsp", i_rsp_valid, 0);

        // contention: expect D,D,D,D,I,D,D,D,D,I
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            i_valid = (c < 10); i_addr = 32'h20;
            d_valid = (c < 10); d_addr = 32'h30; d_we = 0;
            #1;
            if (c < 10) begin
                chk($sformatf("cont_starve_%0d", c), dut.starve_cnt_q, exp_cnt[c]);
                chk($sformatf("cont_i_ready_%0d", c), i_ready, 32'(c == 4 || c == 9));
                chk($sformatf("cont_d_ready_%0d", c), d_ready, 32'(!(c == 4 || c == 9)));
            end
            if (c > 0) begin
                prev_i = (c - 1 == 4) || (c - 1 == 9);
                chk($sformatf("cont_i_rsp_%0d", c), i_rsp_valid, 32'(prev_i));
                chk($sformatf("cont_d_rsp_%0d", c), d_rsp_valid, 32'(!prev_i));
                chk($sformatf("cont_i_rdata_%0d", c), i_rsp_rdata, prev_i ? init_word(8) : 32'h0);
                chk($sformatf("cont_d_rdata_%0d", c), d_rsp_rdata, prev_i ? 32'h0 : init_word(12));
            end
        end
        idle();

        // zero-strobe store, then confirm memory untouched
        @(negedge clk);
        d_valid = 1; d_we = 1; d_wstrb = 0; d_addr = 32'h14; d_wdata = 32'h12345678;
        #1;
        chk("zst_d_ready", d_ready, 1);
        chk("zst_mem_en", mem_en, 1);
        chk("zst_mem_wstrb", mem_wstrb, 0);
        @(negedge clk);
        d_we = 0; d_wdata = 0;
        #1;
        chk("zst_ack_valid", d_rsp_valid, 1);
        chk("zst_ack_rdata", d_rsp_rdata, 0);
        @(negedge clk); idle();
        #1;
        chk("zst_readback", d_rsp_rdata, init_word(5));

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle_mem_en_%0d", c), mem_en, 0);
            chk($sformatf("idle_rsp_%0d", c), {i_rsp_valid, d_rsp_valid}, 0);
        end

        // reset asserted mid-cycle during an accepted D access
        @(negedge clk);
        i_valid = 1; i_addr = 32'h20; d_valid = 1; d_addr = 32'h30;
        #1;
        chk("mrst_pre_d_ready0", d_ready, 1);
        @(negedge clk);
        #1;
        chk("mrst_pre_starve", dut.starve_cnt_q, 1);
        chk("mrst_pre_d_ready1", d_ready, 1);
        chk("mrst_pre_d_rsp", d_rsp_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mrst_d_ready", d_ready, 0);
        chk("mrst_i_ready", i_ready, 0);
        chk("mrst_mem_en", mem_en, 0);
        chk("mrst_starve", dut.starve_cnt_q, 0);
        chk("mrst_d_rsp", d_rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("mrst_edge_d_rsp", d_rsp_valid, 0);
        chk("mrst_edge_i_rsp", i_rsp_valid, 0);
        chk("mrst_edge_mem_en", mem_en, 0);
        chk("mrst_edge_d_rdata", d_rsp_rdata, 0);
        @(negedge clk); idle(); reset = 1'b0;
        #1;
        chk("mrst_rel_mem_en", mem_en, 0);
        chk("mrst_rel_rsp", {i_rsp_valid, d_rsp_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
